// File: rtl/signed_seq_divider.sv
// Sequential signed divider: restoring division on operand magnitudes, one
// quotient bit per clock, then a single sign-fixup cycle.
module signed_seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  // Handshake: start is sampled only while busy=0; busy rises the cycle after
  // acceptance and falls together with the one-cycle done pulse, so a new
  // start may be presented during the done cycle.
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_next;

  logic [CW-1:0]    cnt;
  logic             neg_a, neg_b, dz;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] dq;      // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH:0]   rem;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;
  logic             divisor_zero;

  assign a_mag_in     = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
  assign b_mag_in     = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;
  assign divisor_zero = (divisor == '0);
  assign diff         = {rem, dq[WIDTH-1]} - {2'b00, b_mag};
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = divisor_zero ? FIX : CALC;
      CALC:    if (cnt == CNT_LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      neg_a       <= 1'b0;
      neg_b       <= 1'b0;
      dz          <= 1'b0;
      b_mag       <= '0;
      dq          <= '0;
      rem         <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= (state == FIX);
      case (state)
        IDLE: begin
          if (start) begin
            neg_a <= dividend[WIDTH-1];
            neg_b <= divisor[WIDTH-1];
            dz    <= divisor_zero;
            b_mag <= b_mag_in;
            dq    <= a_mag_in;
            cnt   <= '0;
            // Divide-by-zero parks |dividend| here so FIX re-signs it as the remainder.
            rem   <= divisor_zero ? {1'b0, a_mag_in} : '0;
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (!diff[WIDTH+1]) begin
            rem <= diff[WIDTH:0];
            dq  <= {dq[WIDTH-2:0], 1'b1};
          end else begin
            rem <= {rem[WIDTH-1:0], dq[WIDTH-1]};
            dq  <= {dq[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          quotient    <= dz ? '1 : ((neg_a ^ neg_b) ? (~dq + WIDTH'(1)) : dq);
          remainder   <= neg_a ? (~rem[WIDTH-1:0] + WIDTH'(1)) : rem[WIDTH-1:0];
          div_by_zero <= dz;
          // Only most-negative / -1 yields a magnitude quotient of 2^(WIDTH-1) with equal signs.
          overflow    <= !dz && neg_a && neg_b && (b_mag == WIDTH'(1)) && (dq == MOST_NEG);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_seq_divider.sv
// Self-checking bench for signed_seq_divider: vector table, protocol corner
// sequences and an exhaustive WIDTH=4 sweep, all through an expected queue.
module tb_signed_seq_divider;

  localparam int W  = 4;
  localparam int RW = 2 * W + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero, overflow;
  logic [W-1:0] quotient, remainder;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  logic [RW-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a, b, q, r;
    logic         dz, ovf;
  } vec_t;
  vec_t vecs[9];

  signed_seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] pack(input logic [W-1:0] q, input logic [W-1:0] r,
                                         input logic dz, input logic ovf);
    return {q, r, dz, ovf};
  endfunction

  // Behavioural model: integer division truncates toward zero, % follows the dividend.
  function automatic logic [RW-1:0] model(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    int ai, bi, qi, ri;
    ai = a;
    bi = b;
    if (bi == 0) return pack('1, a, 1'b1, 1'b0);
    if (ai == -(1 << (W - 1)) && bi == -1) return pack(W'(1 << (W - 1)), '0, 1'b0, 1'b1);
    qi = ai / bi;
    ri = ai % bi;
    return pack(W'(qi), W'(ri), 1'b0, 1'b0);
  endfunction

  function automatic vec_t mk(input int a, input int b, input int q, input int r,
                              input logic dz, input logic ovf);
    vec_t v;
    v.a = W'(a); v.b = W'(b); v.q = W'(q); v.r = W'(r); v.dz = dz; v.ovf = ovf;
    return v;
  endfunction

  // scoreboard: pop one expectation per done pulse
  always @(posedge clk) begin
    #1;
    if (rst_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        check("result{q,r,dz,ovf}", 32'({quotient, remainder, div_by_zero, overflow}),
              32'(exp_q.pop_front()));
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // driver: wait for idle, present operands for one edge
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic push, input logic [RW-1:0] exp);
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) exp_q.push_back(exp);
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 50) begin
      @(posedge clk); #1; cycles++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [RW-1:0] exp, input int exp_lat);
    int lat;
    start_op(a, b, 1'b1, exp);
    wait_done(lat);
    if (exp_lat > 0) check("latency", 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    int lat, d0;
    vecs[0] = mk( 7,  3,  2,  1, 1'b0, 1'b0);
    vecs[1] = mk(-7,  2, -3, -1, 1'b0, 1'b0);
    vecs[2] = mk( 7, -2, -3,  1, 1'b0, 1'b0);
    vecs[3] = mk(-3, -7,  0, -3, 1'b0, 1'b0);
    vecs[4] = mk(-8,  7, -1, -1, 1'b0, 1'b0);
    vecs[5] = mk(-8, -1, -8,  0, 1'b0, 1'b1);
    vecs[6] = mk( 5,  0, -1,  5, 1'b1, 1'b0);
    vecs[7] = mk( 6,  4,  1,  2, 1'b0, 1'b0);
    vecs[8] = mk(-6, -4,  1, -2, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_outputs", 32'({quotient, remainder, div_by_zero, overflow}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // table vectors, with the latency fixed by divisor zero / non-zero
    for (int i = 0; i < 9; i++)
      run_op(vecs[i].a, vecs[i].b, pack(vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ovf),
             (vecs[i].b == '0) ? 2 - 1 : W + 1);

    // start while busy is ignored
    d0 = done_cnt;
    start_op(W'(7), W'(3), 1'b1, pack(W'(2), W'(1), 1'b0, 1'b0));
    @(posedge clk); #1;
    @(negedge clk);
    dividend = W'(6); divisor = W'(4); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    repeat (8) @(posedge clk);
    #1;
    check("ignored_start_done_count", 32'(done_cnt - d0), 32'd1);
    check("ignored_start_queue", 32'(exp_q.size()), 32'd0);

    // back-to-back: new start during the done cycle
    start_op(W'(7), W'(3), 1'b1, pack(W'(2), W'(1), 1'b0, 1'b0));
    wait_done(lat);
    start_op(W'(6), W'(4), 1'b1, pack(W'(1), W'(2), 1'b0, 1'b0));
    check("b2b_accepted_busy", 32'(busy), 32'd1);
    wait_done(lat);
    check("b2b_latency", 32'(lat), 32'(W + 1));

    // asynchronous reset mid-operation aborts without a done pulse
    d0 = done_cnt;
    start_op(W'(7), W'(3), 1'b0, '0);
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_outputs", 32'({quotient, remainder, div_by_zero, overflow}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    run_op(W'(0), W'(-1), pack('0, '0, 1'b0, 1'b0), W + 1);

    // exhaustive sweep against the behavioural model
    for (int a = -(1 << (W - 1)); a < (1 << (W - 1)); a++)
      for (int b = -(1 << (W - 1)); b < (1 << (W - 1)); b++)
        run_op(W'(a), W'(b), model(W'(a), W'(b)), (b == 0) ? 1 : W + 1);

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
